// File: rtl/axi_ddc_oct_tone_loader_if.sv
// rtl/axi_ddc_oct_tone_loader_if.sv - DDC tone-configuration port bundle for the tone loader
interface axi_ddc_oct_tone_loader_if #(
  parameter int CH_W = 10
);
  // Load control
  logic            start;
  logic [CH_W-1:0] num_ch;
  logic            do_resync;
  // Tone table RAM
  logic            tbl_en;
  logic [CH_W-1:0] tbl_addr;
  logic [63:0]     tbl_data;
  // Software register path
  logic [31:0]     sw_ch;
  logic [31:0]     sw_pinc;
  logic [31:0]     sw_poff;
  logic            sw_pvalid;
  logic            sw_resync;
  // DDC side
  logic [31:0]     ch;
  logic [31:0]     pinc;
  logic [31:0]     poff;
  logic            pvalid;
  logic            resync;
  // Status
  logic            busy;
  logic            gate_hold;
  logic            done;
  logic            err_sw_drop;

  modport slave (
    input  start, num_ch, do_resync, tbl_data,
    input  sw_ch, sw_pinc, sw_poff, sw_pvalid, sw_resync,
    output tbl_en, tbl_addr,
    output ch, pinc, poff, pvalid, resync,
    output busy, gate_hold, done, err_sw_drop
  );

  modport master (
    output start, num_ch, do_resync, tbl_data,
    output sw_ch, sw_pinc, sw_poff, sw_pvalid, sw_resync,
    input  tbl_en, tbl_addr,
    input  ch, pinc, poff, pvalid, resync,
    input  busy, gate_hold, done, err_sw_drop
  );
endinterface

// File: rtl/axi_ddc_oct_tone_loader.sv
// rtl/axi_ddc_oct_tone_loader.sv - tone table sequencer and software/port arbiter for the DDC
module axi_ddc_oct_tone_loader #(
  parameter int CH_W = 10,
  parameter int GAP  = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  axi_ddc_oct_tone_loader_if.slave      bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, HOLD, RSYNC, DONE} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t          state;
  logic [CH_W-1:0] idx;
  logic [CH_W-1:0] num_q;
  logic            rsync_q;
  logic [7:0]      gap_cnt;
  logic [CH_W:0]   idx_inc;

  // One bit wider than idx so the "more entries left" compare cannot wrap.
  assign idx_inc = {1'b0, idx} + (CH_W+1)'(1);

  // Load sequencer; every port output is a register written here.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state           <= IDLE;
      idx             <= '0;
      num_q           <= '0;
      rsync_q         <= 1'b0;
      gap_cnt         <= '0;
      bus.tbl_en      <= 1'b0;
      bus.tbl_addr    <= '0;
      bus.ch          <= '0;
      bus.pinc        <= '0;
      bus.poff        <= '0;
      bus.pvalid      <= 1'b0;
      bus.resync      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.gate_hold   <= 1'b0;
      bus.done        <= 1'b0;
      bus.err_sw_drop <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      bus.pvalid <= 1'b0;
      bus.resync <= 1'b0;
      bus.done   <= 1'b0;
      bus.tbl_en <= 1'b0;

      // The loader owns the port while busy; any software strobe is lost and remembered.
      if (state != IDLE && (bus.sw_pvalid || bus.sw_resync))
        bus.err_sw_drop <= 1'b1;

      case (state)
        IDLE: begin
          bus.ch        <= bus.sw_ch;
          bus.pinc      <= bus.sw_pinc;
          bus.poff      <= bus.sw_poff;
          bus.pvalid    <= bus.sw_pvalid;
          bus.resync    <= bus.sw_resync;
          // busy also covers the cycle carrying done, so it falls one cycle after it.
          bus.busy      <= bus.start;
          bus.gate_hold <= bus.start;
          if (bus.start) begin
            num_q           <= bus.num_ch;
            rsync_q         <= bus.do_resync;
            bus.err_sw_drop <= 1'b0;
            idx             <= '0;
            if (bus.num_ch != '0) begin
              state        <= RD;
              bus.tbl_en   <= 1'b1;
              bus.tbl_addr <= '0;
            end else if (bus.do_resync) begin
              state <= RSYNC;
            end else begin
              state <= DONE;
            end
          end
        end

        RD: state <= CAP;

        CAP: begin
          bus.pinc   <= bus.tbl_data[31:0];
          bus.poff   <= bus.tbl_data[63:32];
          bus.ch     <= {{(32-CH_W){1'b0}}, idx};
          bus.pvalid <= 1'b1;
          gap_cnt    <= '0;
          state      <= HOLD;
        end

        HOLD: begin
          if (gap_cnt == GAP_LAST) begin
            if (idx_inc < {1'b0, num_q}) begin
              idx          <= idx_inc[CH_W-1:0];
              bus.tbl_en   <= 1'b1;
              bus.tbl_addr <= idx_inc[CH_W-1:0];
              state        <= RD;
            end else if (rsync_q) begin
              state <= RSYNC;
            end else begin
              state <= DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        RSYNC: begin
          bus.resync <= 1'b1;
          state      <= DONE;
        end

        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ddc_oct_tone_loader.sv
// tb/tb_axi_ddc_oct_tone_loader.sv - directed self-checking bench for the DDC tone loader
module tb_axi_ddc_oct_tone_loader;

  logic clk;
  logic rst;
  logic [63:0] ram_q;
  logic [63:0] mem [0:15];
  int tests;
  int fails;

  axi_ddc_oct_tone_loader_if #(.CH_W(10)) bus();

  axi_ddc_oct_tone_loader #(.CH_W(10), .GAP(4)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table RAM with one cycle of read latency
  always @(posedge clk) if (bus.tbl_en) ram_q <= mem[bus.tbl_addr[3:0]];
  assign bus.tbl_data = ram_q;

  typedef struct {
    logic [31:0] ch;
    logic [31:0] pinc;
    logic [31:0] poff;
    logic        pv;
    logic        rs;
    logic [31:0] e_ch;
    logic [31:0] e_pinc;
    logic [31:0] e_poff;
    logic        e_pv;
    logic        e_rs;
  } pt_vec_t;

  typedef struct {
    int   n;
    logic r;
    int   e_pv;
    int   e_rs_cyc;
    int   e_done_cyc;
  } ld_vec_t;

  pt_vec_t pt_tab [0:2];
  ld_vec_t ld_tab [0:5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a load at cycle 0 and watch cycles 1..40; pvalid k must land at 3+6k.
  task automatic run_load(input int n, input logic r, input int e_pv, input int e_rs, input int e_done);
    int pv_n = 0;
    int rs_cyc = 0;
    int rs_n = 0;
    int done_cyc = 0;
    int done_n = 0;
    int en_n = 0;
    int busy_err = 0;
    int gate_err = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_ch = 10'(n);
    bus.do_resync = r;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.pvalid) begin
        check("pv_cycle", 64'(c), 64'(3 + 6 * pv_n));
        check("pv_ch", 64'(bus.ch), 64'(pv_n));
        check("pv_pinc", 64'(bus.pinc), 64'(2 * pv_n + 1));
        check("pv_poff", 64'(bus.poff), 64'(2 * pv_n + 2));
        pv_n++;
      end
      if (bus.resync) begin rs_cyc = c; rs_n++; end
      if (bus.done) begin done_cyc = c; done_n++; end
      if (bus.tbl_en) en_n++;
      if (bus.busy !== (c <= e_done)) busy_err++;
      if (bus.gate_hold !== bus.busy) gate_err++;
    end
    check("pv_count", 64'(pv_n), 64'(e_pv));
    check("resync_cycle", 64'(rs_cyc), 64'(e_rs));
    check("resync_count", 64'(rs_n), 64'((e_rs != 0) ? 1 : 0));
    check("done_cycle", 64'(done_cyc), 64'(e_done));
    check("done_count", 64'(done_n), 64'(1));
    check("tbl_en_count", 64'(en_n), 64'(n));
    check("busy_profile", 64'(busy_err), 64'(0));
    check("gate_hold_eq_busy", 64'(gate_err), 64'(0));
    check("no_drop_flag", 64'(bus.err_sw_drop), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pv_n;
    int done_n;
    int rs_n;
    int busy_n;
    tests = 0;
    fails = 0;
    for (int k = 0; k < 16; k++) mem[k] = {32'(2 * k + 2), 32'(2 * k + 1)};

    pt_tab[0] = '{32'd7, 32'h1234, 32'd0, 1'b1, 1'b0, 32'd7, 32'h1234, 32'd0, 1'b1, 1'b0};
    pt_tab[1] = '{32'd3, 32'd5, 32'd9, 1'b0, 1'b1, 32'd3, 32'd5, 32'd9, 1'b0, 1'b1};
    pt_tab[2] = '{32'hdead, 32'hbeef, 32'hcafe, 1'b0, 1'b0, 32'hdead, 32'hbeef, 32'hcafe, 1'b0, 1'b0};

    ld_tab[0] = '{3, 1'b0, 3, 0, 20};
    ld_tab[1] = '{3, 1'b1, 3, 20, 21};
    ld_tab[2] = '{0, 1'b1, 0, 2, 3};
    ld_tab[3] = '{0, 1'b0, 0, 0, 2};
    ld_tab[4] = '{1, 1'b0, 1, 0, 8};
    ld_tab[5] = '{1, 1'b1, 1, 8, 9};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_ch = '0;
    bus.do_resync = 1'b0;
    bus.sw_ch = '0;
    bus.sw_pinc = '0;
    bus.sw_poff = '0;
    bus.sw_pvalid = 1'b0;
    bus.sw_resync = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({bus.pvalid, bus.resync, bus.done, bus.busy, bus.gate_hold, bus.tbl_en, bus.err_sw_drop}), 64'(0));
    check("reset_ch", 64'(bus.ch), 64'(0));
    check("reset_pinc_poff", {bus.pinc, bus.poff}, 64'(0));
    rst = 1'b0;

    // Idle passthrough, one cycle latency
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sw_ch = pt_tab[i].ch;
      bus.sw_pinc = pt_tab[i].pinc;
      bus.sw_poff = pt_tab[i].poff;
      bus.sw_pvalid = pt_tab[i].pv;
      bus.sw_resync = pt_tab[i].rs;
      @(negedge clk);
      check("pt_ch", 64'(bus.ch), 64'(pt_tab[i].e_ch));
      check("pt_pinc", 64'(bus.pinc), 64'(pt_tab[i].e_pinc));
      check("pt_poff", 64'(bus.poff), 64'(pt_tab[i].e_poff));
      check("pt_pvalid", 64'(bus.pvalid), 64'(pt_tab[i].e_pv));
      check("pt_resync", 64'(bus.resync), 64'(pt_tab[i].e_rs));
      bus.sw_pvalid = 1'b0;
      bus.sw_resync = 1'b0;
    end
    check("pt_no_drop", 64'(bus.err_sw_drop), 64'(0));
    bus.sw_ch = '0;
    bus.sw_pinc = '0;
    bus.sw_poff = '0;
    repeat (2) @(negedge clk);

    // Table-driven loads
    for (int i = 0; i < 6; i++)
      run_load(ld_tab[i].n, ld_tab[i].r, ld_tab[i].e_pv, ld_tab[i].e_rs_cyc, ld_tab[i].e_done_cyc);

    // Software strobes and a second start during HOLD of a 2-entry load
    pv_n = 0;
    done_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_ch = 10'd2;
    bus.do_resync = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 5) begin
        check("drop_no_pvalid", 64'(bus.pvalid), 64'(0));
        check("drop_no_resync", 64'(bus.resync), 64'(0));
        check("drop_ch_held", 64'(bus.ch), 64'(0));
        check("drop_flag_set", 64'(bus.err_sw_drop), 64'(1));
        bus.sw_pvalid = 1'b0;
        bus.sw_resync = 1'b0;
        bus.sw_ch = '0;
        bus.start = 1'b0;
        bus.num_ch = 10'd2;
      end
      if (bus.pvalid) begin
        pv_n++;
        if (c == 9) check("drop_second_entry_ch", 64'(bus.ch), 64'(1));
      end
      if (bus.done) begin
        done_n++;
        check("drop_done_cycle", 64'(c), 64'(14));
      end
      if (c == 4) begin
        bus.sw_pvalid = 1'b1;
        bus.sw_resync = 1'b1;
        bus.sw_ch = 32'd99;
        bus.start = 1'b1;
        bus.num_ch = 10'd5;
      end
    end
    check("drop_pv_count", 64'(pv_n), 64'(2));
    check("drop_done_count", 64'(done_n), 64'(1));
    check("drop_flag_sticky", 64'(bus.err_sw_drop), 64'(1));
    check("drop_idle_busy", 64'(bus.busy), 64'(0));

    // Start with a simultaneous software publish: forwarded, flag cleared
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_ch = 10'd0;
    bus.do_resync = 1'b0;
    bus.sw_pvalid = 1'b1;
    bus.sw_ch = 32'd11;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sw_pvalid = 1'b0;
    bus.sw_ch = '0;
    check("start_sw_pvalid", 64'(bus.pvalid), 64'(1));
    check("start_sw_ch", 64'(bus.ch), 64'(11));
    check("start_clears_flag", 64'(bus.err_sw_drop), 64'(0));
    @(negedge clk);
    check("start_sw_not_dropped", 64'(bus.err_sw_drop), 64'(0));
    repeat (4) @(negedge clk);

    // Reset during the second entry's CAP (cycle 8)
    pv_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_ch = 10'd3;
    bus.do_resync = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.pvalid) pv_n++;
    end
    check("abort_pv_before", 64'(pv_n), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs",
          64'({bus.pvalid, bus.resync, bus.done, bus.busy, bus.gate_hold, bus.tbl_en, bus.err_sw_drop}), 64'(0));
    check("abort_ch_pinc", {bus.ch, bus.pinc}, 64'(0));
    check("abort_poff_addr", {bus.poff, 22'd0, bus.tbl_addr}, 64'(0));
    pv_n = 0;
    done_n = 0;
    rs_n = 0;
    busy_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.pvalid) pv_n++;
      if (bus.done) done_n++;
      if (bus.resync) rs_n++;
      if (bus.busy) busy_n++;
    end
    check("abort_no_pvalid", 64'(pv_n), 64'(0));
    check("abort_no_done", 64'(done_n), 64'(0));
    check("abort_no_resync", 64'(rs_n), 64'(0));
    check("abort_idle", 64'(busy_n), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
